// File: rtl/sky130_fd_io__gdx_handshake_rx.sv
// Receive end of a 2-phase toggle req/ack link between two separately bonded ground domains.
// Synchronizes and deglitches the remote req toggle, presents the word on valid/ready, returns a toggle ack.
module sky130_fd_io__gdx_handshake_rx #(
    parameter int DW          = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEGLITCH    = 3
) (
`ifdef USE_POWER_PINS
    inout  wire           vccd,
    inout  wire           vssd,
`endif
    input  logic          clk,
    input  logic          rst,
    input  logic          req_tgl_a,
    input  logic [DW-1:0] data_a,
    output logic          ack_tgl,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    glitch_cnt,
    output logic          proto_err
);

    localparam int              CNT_W   = (DEGLITCH < 2) ? 1 : $clog2(DEGLITCH + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEG_MAX = CNT_W'(DEGLITCH);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FILTER = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [1:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   req_acc_q, req_acc_d;
    logic                   ack_q, ack_d;
    logic [DW-1:0]          data_q, data_d;
    logic                   valid_q, valid_d;
    logic [7:0]             glitch_q, glitch_d;
    logic                   proto_q, proto_d;
    logic                   req_s;

    assign req_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], req_tgl_a};
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_acc_d = req_acc_q;
        ack_d     = ack_q;
        data_d    = data_q;
        valid_d   = valid_q;
        glitch_d  = glitch_q;
        proto_d   = proto_q;

        case (state_q)
            ST_IDLE: begin
                if (req_s != req_acc_q) begin
                    state_d = ST_FILTER;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_FILTER: begin
                // A req that falls back before the window closes is ground bounce, not a request.
                if (req_s == req_acc_q) begin
                    state_d = ST_IDLE;
                    if (glitch_q != 8'hFF) begin
                        glitch_d = glitch_q + 8'd1;
                    end
                end else if (cnt_q == DEG_MAX) begin
                    data_d    = data_a;
                    valid_d   = 1'b1;
                    req_acc_d = req_s;
                    state_d   = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (req_s != req_acc_q) begin
                    proto_d = 1'b1;
                end
                if (valid_q && out_ready) begin
                    valid_d = 1'b0;
                    ack_d   = req_acc_q;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= '0;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            req_acc_q <= 1'b0;
            ack_q     <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            glitch_q  <= 8'd0;
            proto_q   <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_acc_q <= req_acc_d;
            ack_q     <= ack_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            glitch_q  <= glitch_d;
            proto_q   <= proto_d;
        end
    end

    assign ack_tgl    = ack_q;
    assign out_data   = data_q;
    assign out_valid  = valid_q;
    assign glitch_cnt = glitch_q;
    assign proto_err  = proto_q;

endmodule

// File: tb/tb_sky130_fd_io__gdx_handshake_rx.sv
// Randomized bench for the ground-domain handshake receiver against a transaction-level reference model.
// The model predicts outcomes from pulse widths and fixed latency arithmetic, not from internal state.
module tb_sky130_fd_io__gdx_handshake_rx;

    localparam int DW          = 8;
    localparam int SYNC_STAGES = 2;
    localparam int DEGLITCH    = 3;
    localparam int LATENCY     = SYNC_STAGES + DEGLITCH + 1;

    logic          clk;
    logic          rst;
    logic          req_tgl_a;
    logic [DW-1:0] data_a;
    logic          ack_tgl;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    glitch_cnt;
    logic          proto_err;

    int checks = 0;
    int errors = 0;

    logic       model_req;
    logic       model_ack;
    logic [7:0] model_glitch;
    logic       model_proto;

    sky130_fd_io__gdx_handshake_rx #(
        .DW(DW), .SYNC_STAGES(SYNC_STAGES), .DEGLITCH(DEGLITCH)
    ) dut (
        .clk(clk), .rst(rst), .req_tgl_a(req_tgl_a), .data_a(data_a),
        .ack_tgl(ack_tgl), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .glitch_cnt(glitch_cnt), .proto_err(proto_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic req, input logic [DW-1:0] data, input logic ready);
        req_tgl_a = req;
        data_a    = data;
        out_ready = ready;
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput({tag, "_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_ack"}, 32'(ack_tgl), 32'(model_ack));
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(1'b0, DW'($urandom), 1'b0);
        @(negedge clk);
        rst = 1'b0;
        model_req    = 1'b0;
        model_ack    = 1'b0;
        model_glitch = 8'd0;
        model_proto  = 1'b0;
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_data", 32'(out_data), 32'd0);
        checkOutput("rst_ack", 32'(ack_tgl), 32'd0);
        checkOutput("rst_glitch", 32'(glitch_cnt), 32'd0);
        checkOutput("rst_proto", 32'(proto_err), 32'd0);
    endtask

    // Toggle req with a clean word and wait exactly until the word is presented.
    task automatic reachHold(input logic [DW-1:0] data);
        model_req = ~model_req;
        applyStimulus(model_req, data, 1'b0);
        for (int i = 1; i < LATENCY; i++) begin
            @(negedge clk);
            checkQuiet("lat_wait");
        end
        @(negedge clk);
        checkOutput("lat_valid", 32'(out_valid), 32'd1);
        checkOutput("lat_data", 32'(out_data), 32'(data));
    endtask

    task automatic doTransfer(input logic [DW-1:0] data, input int ready_delay);
        reachHold(data);
        for (int i = 0; i < ready_delay; i++) begin
            @(negedge clk);
            checkOutput("bp_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_data", 32'(out_data), 32'(data));
            checkOutput("bp_ack", 32'(ack_tgl), 32'(model_ack));
        end
        applyStimulus(model_req, data, 1'b1);
        @(negedge clk);
        model_ack = model_req;
        checkOutput("hs_valid", 32'(out_valid), 32'd0);
        checkOutput("hs_ack", 32'(ack_tgl), 32'(model_ack));
        applyStimulus(model_req, DW'($urandom), 1'b0);
    endtask

    // A pulse shorter than DEGLITCH+1 synchronized cycles must be rejected and counted.
    task automatic doGlitch(input int width);
        applyStimulus(~model_req, data_a, 1'b0);
        for (int i = 0; i < width; i++) begin
            @(negedge clk);
            checkQuiet("gl_pulse");
        end
        applyStimulus(model_req, data_a, 1'b0);
        for (int i = 0; i < SYNC_STAGES + DEGLITCH + 2; i++) begin
            @(negedge clk);
            checkQuiet("gl_after");
        end
        if (model_glitch != 8'd255) model_glitch = model_glitch + 8'd1;
        checkOutput("gl_cnt", 32'(glitch_cnt), 32'(model_glitch));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, '0, 1'b0);
        repeat (2) @(negedge clk);
        doReset();

        $display("[TB] clean transfer");
        doTransfer(8'hA5, 0);

        $display("[TB] glitch rejection");
        doGlitch(2);

        $display("[TB] backpressure");
        doTransfer(8'h5A, 10);

        $display("[TB] protocol error");
        reachHold(8'h3C);
        model_req = ~model_req;
        applyStimulus(model_req, 8'h3C, 1'b0);
        repeat (SYNC_STAGES + 2) @(negedge clk);
        checkOutput("pe_proto", 32'(proto_err), 32'd1);
        checkOutput("pe_valid", 32'(out_valid), 32'd1);
        checkOutput("pe_data", 32'(out_data), 32'h3C);
        doReset();
        doTransfer(8'hC3, 1);
        checkOutput("pe_cleared", 32'(proto_err), 32'd0);

        $display("[TB] reset mid-transfer");
        model_req = ~model_req;
        applyStimulus(model_req, 8'h11, 1'b0);
        repeat (SYNC_STAGES + 1) @(negedge clk);
        doReset();
        doTransfer(8'h22, 2);
        reachHold(8'h33);
        doReset();
        doTransfer(8'h44, 0);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                doGlitch(int'($urandom_range(1, DEGLITCH)));
            end else begin
                doTransfer(DW'($urandom), int'($urandom_range(0, 5)));
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("[TB] glitch counter saturation");
        doReset();
        for (int n = 0; n < 300; n++) begin
            doGlitch(int'($urandom_range(1, DEGLITCH)));
        end
        checkOutput("sat_cnt", 32'(glitch_cnt), 32'd255);
        checkOutput("sat_ack", 32'(ack_tgl), 32'd0);
        doTransfer(8'h99, 0);
        checkOutput("sat_hold", 32'(glitch_cnt), 32'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
